// File: rtl/serial_input_regs_pkg.sv
// Shared types for the host-to-AGC serial input path: register selects, frame tag,
// error codes and FSM state encodings.
package serial_input_regs_pkg;

  typedef enum logic [4:0] {
    SEL_VERB         = 5'd0,
    SEL_NOUN         = 5'd1,
    SEL_MISSION_TIME = 5'd2,
    SEL_APOGEE       = 5'd3,
    SEL_PERIGEE      = 5'd4
  } sel_e;

  localparam logic [2:0] HDR_TAG = 3'b101;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_FRAMING  = 3'd1,
    ERR_HEADER   = 3'd2,
    ERR_SELECT   = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_CHECKSUM = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    P_HDR = 2'd0,
    P_HI  = 2'd1,
    P_LO  = 2'd2,
    P_CK  = 2'd3
  } pstate_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxstate_e;

endpackage

// File: rtl/serial_input_regs_uart_rx_byte.sv
// UART byte receiver: 2-flop rx synchronizer plus start/data/stop FSM.
// IDLE: wait for low | START: confirm start mid-bit | DATA: 8 LSB-first samples | STOP: check stop bit
module uart_rx_byte
  import serial_input_regs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2);

  logic           sync1_q, rx_s_q;
  rxstate_e       state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Terminal count at 1 keeps the bit period exactly CLKS_PER_BIT after a reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    expire  = (cnt_q == CW'(1));
    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (expire) begin
          state_d = RX_IDLE;
          if (rx_s_q) valid_d = 1'b1;
          else        ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/serial_input_regs.sv
// Serial frame parser driving the five CPU input registers. Define FRAME_CHECKSUM_EN
// for a 4th XOR checksum byte. HDR: header | HI: data[14:8] | LO: data[7:0] | CK: checksum
module serial_input_regs
  import serial_input_regs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [14:0] dsky_verb_data,
  output logic [14:0] dsky_noun_data,
  output logic [14:0] mission_time_data,
  output logic [14:0] apogee_data,
  output logic [14:0] perigee_data,
  output logic        upd_valid,
  output logic [4:0]  upd_sel,
  output logic        err_pulse,
  output logic [2:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  pstate_e     state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  logic [6:0]  hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [14:0] verb_q, verb_d, noun_q, noun_d, mt_q, mt_d, apo_q, apo_d, per_q, per_d;
  logic        upd_valid_q, upd_valid_d, err_pulse_q, err_pulse_d;
  logic [4:0]  upd_sel_q, upd_sel_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        commit;
  logic [14:0] commit_data;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  lo_q, lo_d, sum_q, sum_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= P_HDR;
      sel_q       <= '0;
      hi_q        <= '0;
      tmo_q       <= TMO_LOAD;
      verb_q      <= '0;
      noun_q      <= '0;
      mt_q        <= '0;
      apo_q       <= '0;
      per_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_sel_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
      lo_q        <= '0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hi_q        <= hi_d;
      tmo_q       <= tmo_d;
      verb_q      <= verb_d;
      noun_q      <= noun_d;
      mt_q        <= mt_d;
      apo_q       <= apo_d;
      per_q       <= per_d;
      upd_valid_q <= upd_valid_d;
      upd_sel_q   <= upd_sel_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef FRAME_CHECKSUM_EN
      lo_q        <= lo_d;
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hi_d        = hi_q;
    verb_d      = verb_q;
    noun_d      = noun_q;
    mt_d        = mt_q;
    apo_d       = apo_q;
    per_d       = per_q;
    upd_valid_d = 1'b0;
    upd_sel_d   = upd_sel_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    commit      = 1'b0;
    commit_data = '0;
`ifdef FRAME_CHECKSUM_EN
    lo_d        = lo_q;
    sum_d       = sum_q;
`endif
    // Gap timer restarts on every byte and idles at full count while waiting for a header.
    if (state_q == P_HDR || byte_valid) tmo_d = TMO_LOAD;
    else if (tmo_q != '0)               tmo_d = tmo_q - 1'b1;
    else                                tmo_d = tmo_q;

    if (frame_err) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_FRAMING;
      state_d     = P_HDR;
    end else if (byte_valid) begin
      case (state_q)
        P_HDR: begin
          if (byte_data[7:5] != HDR_TAG) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_HEADER;
          end else if (byte_data[4:0] > SEL_PERIGEE) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SELECT;
          end else begin
            sel_d   = byte_data[4:0];
            state_d = P_HI;
`ifdef FRAME_CHECKSUM_EN
            sum_d   = byte_data;
`endif
          end
        end
        P_HI: begin
          if (byte_data[7]) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_HEADER;
            state_d     = P_HDR;
          end else begin
            hi_d    = byte_data[6:0];
            state_d = P_LO;
`ifdef FRAME_CHECKSUM_EN
            sum_d   = sum_q ^ byte_data;
`endif
          end
        end
        P_LO: begin
`ifdef FRAME_CHECKSUM_EN
          lo_d    = byte_data;
          sum_d   = sum_q ^ byte_data;
          state_d = P_CK;
`else
          commit      = 1'b1;
          commit_data = {hi_q, byte_data};
          state_d     = P_HDR;
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        P_CK: begin
          if (byte_data == sum_q) begin
            commit      = 1'b1;
            commit_data = {hi_q, lo_q};
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
          end
          state_d = P_HDR;
        end
`endif
        default: state_d = P_HDR;
      endcase
    end else if (state_q != P_HDR && tmo_q == '0) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = P_HDR;
    end

    if (commit) begin
      upd_valid_d = 1'b1;
      upd_sel_d   = sel_q;
      case (sel_q)
        SEL_VERB:         verb_d = commit_data;
        SEL_NOUN:         noun_d = commit_data;
        SEL_MISSION_TIME: mt_d   = commit_data;
        SEL_APOGEE:       apo_d  = commit_data;
        SEL_PERIGEE:      per_d  = commit_data;
        default: ;
      endcase
    end
  end

  assign dsky_verb_data    = verb_q;
  assign dsky_noun_data    = noun_q;
  assign mission_time_data = mt_q;
  assign apogee_data       = apo_q;
  assign perigee_data      = per_q;
  assign upd_valid         = upd_valid_q;
  assign upd_sel           = upd_sel_q;
  assign err_pulse         = err_pulse_q;
  assign err_code          = err_code_q;

endmodule
